// File: rtl/nav_pkg.sv
// Shared types and constants for the navigation controller: state encoding,
// forward speed limits and the two ramp increments (fast simulation / real).
package nav_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADING,
    RAMP_UP,
    DECEL,
    BRAKE
  } nav_state_e;

  localparam logic [10:0] MIN_FRWRD      = 11'h0D0;
  localparam logic [10:0] MAX_FRWRD      = 11'h2A0;
  localparam logic [10:0] FUSION_THRESH  = 11'h150;
  localparam logic [10:0] FRWRD_INC_FAST = 11'h018;
  localparam logic [10:0] FRWRD_INC_SLOW = 11'h002;

endpackage

// File: rtl/navigate_if.sv
// Handshake bundle between the command processor / sensors / PID stage
// (master side) and the navigation controller (slave side).
interface navigate_if;

  logic        strt_hdng;
  logic        strt_mv;
  logic        stp_lft;
  logic        stp_rght;
  logic        at_hdng;
  logic        lft_opn;
  logic        rght_opn;
  logic        frwrd_opn;
  logic        moving;
  logic [10:0] frwrd_spd;
  logic        en_fusion;
  logic        mv_cmplt;

  modport master (
    output strt_hdng, strt_mv, stp_lft, stp_rght, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    input  moving, frwrd_spd, en_fusion, mv_cmplt
  );

  modport slave (
    input  strt_hdng, strt_mv, stp_lft, stp_rght, at_hdng,
           lft_opn, rght_opn, frwrd_opn,
    output moving, frwrd_spd, en_fusion, mv_cmplt
  );

endinterface

// File: rtl/navigate.sv
// Navigation controller: runs heading changes and forward moves, ramping the
// forward speed up, then decelerating at a side opening or braking at a wall.
module navigate
  import nav_pkg::*;
#(
  parameter logic FAST_SIM = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  navigate_if.slave nav
);

  localparam logic [10:0] FRWRD_INC  = FAST_SIM ? FRWRD_INC_FAST : FRWRD_INC_SLOW;
  localparam logic [10:0] DECEL_STEP = FRWRD_INC << 1;
  localparam logic [10:0] BRAKE_STEP = FRWRD_INC << 2;

  nav_state_e  state_q, state_d;
  logic [10:0] frwrdSpd_q, frwrdSpd_d;
  logic        mvCmplt_q, mvCmplt_d;
  logic        lftOpnDly_q, rghtOpnDly_q;
  logic        movingComb;
  logic        lftRise, rghtRise;
  logic [11:0] rampSum;
  logic [10:0] rampSat;
  logic [10:0] downStep;

  // Delayed copies start high so an opening visible out of reset is not an edge
  assign lftRise  = nav.lft_opn  & ~lftOpnDly_q;
  assign rghtRise = nav.rght_opn & ~rghtOpnDly_q;

  // Widen before adding so the saturation compare sees any carry
  assign rampSum  = {1'b0, frwrdSpd_q} + {1'b0, FRWRD_INC};
  assign rampSat  = (rampSum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : rampSum[10:0];
  assign downStep = (state_q == BRAKE) ? BRAKE_STEP : DECEL_STEP;

  // State, speed, completion pulse and edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frwrdSpd_q   <= '0;
      mvCmplt_q    <= 1'b0;
      lftOpnDly_q  <= 1'b1;
      rghtOpnDly_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      frwrdSpd_q   <= frwrdSpd_d;
      mvCmplt_q    <= mvCmplt_d;
      lftOpnDly_q  <= nav.lft_opn;
      rghtOpnDly_q <= nav.rght_opn;
    end
  end

  // Next-state, next-speed and moving decode; speed holds on state changes
  always_comb begin
    state_d    = state_q;
    frwrdSpd_d = frwrdSpd_q;
    mvCmplt_d  = 1'b0;
    movingComb = 1'b1;
    case (state_q)
      IDLE: begin
        movingComb = 1'b0;
        frwrdSpd_d = '0;
        if (nav.strt_hdng) begin
          state_d = HEADING;
        end else if (nav.strt_mv) begin
          state_d    = RAMP_UP;
          frwrdSpd_d = MIN_FRWRD;
        end
      end
      HEADING: begin
        frwrdSpd_d = '0;
        if (nav.at_hdng) begin
          state_d   = IDLE;
          mvCmplt_d = 1'b1;
        end
      end
      RAMP_UP: begin
        if (!nav.frwrd_opn) begin
          state_d = BRAKE;
        end else if ((nav.stp_lft & lftRise) | (nav.stp_rght & rghtRise)) begin
          state_d = DECEL;
        end else begin
          frwrdSpd_d = rampSat;
        end
      end
      DECEL, BRAKE: begin
        if ((state_q == DECEL) && !nav.frwrd_opn) begin
          state_d = BRAKE;
        end else if (frwrdSpd_q <= downStep) begin
          state_d    = IDLE;
          frwrdSpd_d = '0;
          mvCmplt_d  = 1'b1;
        end else begin
          frwrdSpd_d = frwrdSpd_q - downStep;
        end
      end
      default: begin
        state_d    = IDLE;
        frwrdSpd_d = '0;
        movingComb = 1'b0;
      end
    endcase
  end

  assign nav.moving    = movingComb;
  assign nav.frwrd_spd = frwrdSpd_q;
  assign nav.mv_cmplt  = mvCmplt_q;
  assign nav.en_fusion = (frwrdSpd_q > FUSION_THRESH);

endmodule
